mem_port_arbiter: RTL and testbench

//  Shares one single-ported backing memory bus between the pipeline's fetch port (icache_*)
//  and data port (dcache_*); sits between the pipeline top and memory.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter_grant.sv | 33 +++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Holds the FSM state and port id enums plus the default bus widths.
package mriscv_mem_pkg;

    localparam int ADDR_W_DFLT = 32;
    localparam int DATA_W_DFLT = 32;

    typedef enum logic [1:0] {
        IDLE,
        IREQ,
        DREQ
    } arb_state_t;

    typedef enum logic {
        PORT_I,
        PORT_D
    } port_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-ported backing memory bus.
// The arbiter is the master; the memory is the slave.
interface mem_port_arbiter_if
    import mriscv_mem_pkg::*;
#(
    parameter int AW = ADDR_W_DFLT,
    parameter int DW = DATA_W_DFLT
) ();

    logic          mem_req;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_wr,
        output mem_addr,
        output mem_wdata,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_wr,
        input  mem_addr,
        input  mem_wdata,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_grant.sv
// Combinational grant pick between the fetch and data ports.
// ARB_ROUND_ROBIN_EN selects round robin on collisions; otherwise data wins.
module mem_arb_grant
    import mriscv_mem_pkg::*;
(
    input  logic     pend_i,
    input  logic     pend_d,
`ifdef ARB_ROUND_ROBIN_EN
    input  port_id_t last_grant,
`endif
    output logic     grant_i,
    output logic     grant_d
);

    // pick one pending port; data is the older instruction unless rotating
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (pend_i && pend_d) begin
            if (last_grant == PORT_D) grant_i = 1'b1;
            else                      grant_d = 1'b1;
        end else begin
            grant_i = pend_i;
            grant_d = pend_d;
        end
`else
        grant_d = pend_d;
        grant_i = pend_i && !pend_d;
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between fetch and data ports, buffering results.
// Optional macro ARB_ROUND_ROBIN_EN: round-robin grant on collisions.
module mem_port_arbiter
    import mriscv_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_stall,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic [DATA_W-1:0] icache_data,
    output logic              icache_rdy,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    input  logic              dcache_en,
    input  logic              dcache_wr,
    output logic [DATA_W-1:0] dcache_rdata,
    output logic              dcache_rdy,
    mem_port_arbiter_if.master mem
);

    arb_state_t        state, state_nxt;
    logic [ADDR_W-1:0] i_tag;
    logic              i_buf_valid;
    logic              d_done;
    logic              pend_i, pend_d;
    logic              grant_i, grant_d;
    logic              take_i, take_d;

`ifdef ARB_ROUND_ROBIN_EN
    port_id_t          last_grant;
`endif

    assign icache_rdy = i_buf_valid && (i_tag == icache_addr);
    assign dcache_rdy = !dcache_en || d_done;
    assign pend_i     = !icache_rdy;
    assign pend_d     = dcache_en && !d_done;

    mem_arb_grant u_grant (
        .pend_i     (pend_i),
        .pend_d     (pend_d),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant (last_grant),
`endif
        .grant_i    (grant_i),
        .grant_d    (grant_d)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next state, request strobe and grant take-up
    always_comb begin
        state_nxt   = state;
        mem.mem_req = 1'b0;
        take_i      = 1'b0;
        take_d      = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_d) begin
                    take_d    = 1'b1;
                    state_nxt = DREQ;
                end else if (grant_i) begin
                    take_i    = 1'b1;
                    state_nxt = IREQ;
                end
            end
            IREQ, DREQ: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // bus latches, response buffers and consumption
    always_ff @(posedge clock) begin
        if (reset) begin
            mem.mem_wr    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            icache_data   <= '0;
            dcache_rdata  <= '0;
            i_tag         <= '0;
            i_buf_valid   <= 1'b0;
            d_done        <= 1'b0;
        end else begin
            if (!ctrl_stall) begin
                i_buf_valid <= 1'b0;
                d_done      <= 1'b0;
            end
            if (take_i) begin
                mem.mem_addr <= icache_addr;
                mem.mem_wr   <= 1'b0;
            end
            if (take_d) begin
                mem.mem_addr  <= dcache_addr;
                mem.mem_wr    <= dcache_wr;
                mem.mem_wdata <= dcache_wdata;
            end
            if (state == IREQ && mem.mem_ack) begin
                icache_data <= mem.mem_rdata;
                i_tag       <= mem.mem_addr;
                i_buf_valid <= 1'b1;
            end
            if (state == DREQ && mem.mem_ack) begin
                d_done <= 1'b1;
                if (!mem.mem_wr) dcache_rdata <= mem.mem_rdata;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // remember the last port granted for rotation
    always_ff @(posedge clock) begin
        if (reset)       last_grant <= PORT_I;
        else if (take_i) last_grant <= PORT_I;
        else if (take_d) last_grant <= PORT_D;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory.
// Expected bus transactions are queued at stimulus and matched at ack.
module tb_mem_port_arbiter;
    import mriscv_mem_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_stall;
    logic [31:0] icache_addr;
    logic [31:0] icache_data;
    logic        icache_rdy;
    logic [31:0] dcache_addr;
    logic [31:0] dcache_wdata;
    logic        dcache_en;
    logic        dcache_wr;
    logic [31:0] dcache_rdata;
    logic        dcache_rdy;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .ctrl_stall   (ctrl_stall),
        .icache_addr  (icache_addr),
        .icache_data  (icache_data),
        .icache_rdy   (icache_rdy),
        .dcache_addr  (dcache_addr),
        .dcache_wdata (dcache_wdata),
        .dcache_en    (dcache_en),
        .dcache_wr    (dcache_wr),
        .dcache_rdata (dcache_rdata),
        .dcache_rdy   (dcache_rdy),
        .mem          (bus)
    );

    always #5 clock = ~clock;

    int   n_pass = 0;
    int   n_total = 0;
    txn_t exp_q[$];
    txn_t obs_q[$];
    int   ack_delay = 0;
    bit   mem_mute = 1'b0;
    int   mem_cnt = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h0050_0093;
            32'h200: return 32'hDEAD_BEEF;
            default: return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // behavioural memory: acks after ack_delay extra req cycles
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            bus.mem_ack = 1'b0;
            if (!bus.mem_req || mem_mute) begin
                mem_cnt = 0;
            end else if (mem_cnt >= ack_delay) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_word(bus.mem_addr);
                obs_q.push_back('{bus.mem_wr, bus.mem_addr,
                                  bus.mem_wr ? bus.mem_wdata : 32'h0});
                mem_cnt = 0;
            end else begin
                mem_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        ctrl_stall   = 1'b1;
        dcache_en    = 1'b0;
        dcache_wr    = 1'b0;
        dcache_addr  = 32'h0;
        dcache_wdata = 32'h0;
        icache_addr  = 32'h100;
        ack_delay    = 0;
        repeat (3) step();
        n_total++;
        if (icache_rdy !== 1'b0)
            $display("FAIL rst_icache_rdy: got %b want 0", icache_rdy);
        else n_pass++;
        n_total++;
        if (dcache_rdy !== 1'b1)
            $display("FAIL rst_dcache_rdy: got %b want 1", dcache_rdy);
        else n_pass++;
        n_total++;
        if (bus.mem_req !== 1'b0)
            $display("FAIL rst_mem_req: got %b want 0", bus.mem_req);
        else n_pass++;
        n_total++;
        if (bus.mem_addr !== 32'h0)
            $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr);
        else n_pass++;
        n_total++;
        if (icache_data !== 32'h0 || dcache_rdata !== 32'h0)
            $display("FAIL rst_bufs: got %h/%h want 0/0",
                     icache_data, dcache_rdata);
        else n_pass++;
    endtask

    task automatic test_fetch();
        txn_t e, o;
        exp_q.push_back('{1'b0, 32'h100, 32'h0});
        reset = 1'b0;
        step();
        n_total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 ||
            bus.mem_wr !== 1'b0)
            $display("FAIL fetch_issue: got req=%b addr=%h wr=%b want 1/100/0",
                     bus.mem_req, bus.mem_addr, bus.mem_wr);
        else n_pass++;
        step();
        n_total++;
        if (icache_rdy !== 1'b1 || icache_data !== 32'h0050_0093)
            $display("FAIL fetch_latency: got rdy=%b data=%h want 1/00500093",
                     icache_rdy, icache_data);
        else n_pass++;
        step();
        n_total++;
        if (bus.mem_req !== 1'b0 || icache_rdy !== 1'b1)
            $display("FAIL fetch_hold: got req=%b rdy=%b want 0/1",
                     bus.mem_req, icache_rdy);
        else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) begin
                $display("FAIL fetch_txn: got none want %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL fetch_txn: got %p want %p", o, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_collision();
        txn_t e, o;
        exp_q.push_back('{1'b0, 32'h200, 32'h0});
        exp_q.push_back('{1'b0, 32'h140, 32'h0});
        ctrl_stall  = 1'b0;
        dcache_en   = 1'b1;
        dcache_wr   = 1'b0;
        dcache_addr = 32'h200;
        icache_addr = 32'h140;
        step();
        ctrl_stall = 1'b1;
        n_total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h200)
            $display("FAIL coll_first: got req=%b addr=%h want 1/200",
                     bus.mem_req, bus.mem_addr);
        else n_pass++;
        for (int k = 0; k < 20 && !(icache_rdy && dcache_rdy); k++) step();
        n_total++;
        if (icache_rdy !== 1'b1 || dcache_rdy !== 1'b1)
            $display("FAIL coll_both_rdy: got %b/%b want 1/1",
                     icache_rdy, dcache_rdy);
        else n_pass++;
        n_total++;
        if (dcache_rdata !== 32'hDEAD_BEEF || icache_data !== mem_word(32'h140))
            $display("FAIL coll_data: got %h/%h want deadbeef/%h",
                     dcache_rdata, icache_data, mem_word(32'h140));
        else n_pass++;
        ctrl_stall = 1'b0;
        step();
        ctrl_stall = 1'b1;
        n_total++;
        if (icache_rdy !== 1'b0 || dcache_rdy !== 1'b0)
            $display("FAIL coll_consume: got %b/%b want 0/0",
                     icache_rdy, dcache_rdy);
        else n_pass++;
        icache_addr = 32'h144;
        exp_q.push_back('{1'b0, 32'h200, 32'h0});
        exp_q.push_back('{1'b0, 32'h144, 32'h0});
        for (int k = 0; k < 20 && !(icache_rdy && dcache_rdy); k++) step();
        n_total++;
        if (icache_rdy !== 1'b1 || dcache_rdy !== 1'b1)
            $display("FAIL coll_again_rdy: got %b/%b want 1/1",
                     icache_rdy, dcache_rdy);
        else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) begin
                $display("FAIL coll_txn: got none want %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL coll_txn: got %p want %p", o, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_store();
        txn_t e, o;
        int   nreq;
        bit   stable;
        ctrl_stall = 1'b0;
        dcache_en  = 1'b0;
        step();
        ctrl_stall   = 1'b1;
        ack_delay    = 2;
        dcache_en    = 1'b1;
        dcache_wr    = 1'b1;
        dcache_addr  = 32'h300;
        dcache_wdata = 32'h1234_5678;
        icache_addr  = 32'h148;
        exp_q.push_back('{1'b1, 32'h300, 32'h1234_5678});
        exp_q.push_back('{1'b0, 32'h148, 32'h0});
        step();
        nreq   = 0;
        stable = 1'b1;
        for (int k = 0; k < 10 && !dcache_rdy; k++) begin
            if (bus.mem_req) nreq++;
            if (bus.mem_addr !== 32'h300 || bus.mem_wdata !== 32'h1234_5678 ||
                bus.mem_wr !== 1'b1)
                stable = 1'b0;
            step();
        end
        n_total++;
        if (nreq !== 3)
            $display("FAIL store_req_cycles: got %0d want 3", nreq);
        else n_pass++;
        n_total++;
        if (stable !== 1'b1)
            $display("FAIL store_stable: got %b want 1", stable);
        else n_pass++;
        n_total++;
        if (dcache_rdy !== 1'b1 || bus.mem_req !== 1'b0)
            $display("FAIL store_done: got rdy=%b req=%b want 1/0",
                     dcache_rdy, bus.mem_req);
        else n_pass++;
        n_total++;
        if (dcache_rdata !== 32'hDEAD_BEEF)
            $display("FAIL store_rdata: got %h want deadbeef", dcache_rdata);
        else n_pass++;
        for (int k = 0; k < 20 && !icache_rdy; k++) step();
        n_total++;
        if (icache_rdy !== 1'b1 || icache_data !== mem_word(32'h148))
            $display("FAIL store_fetch: got rdy=%b data=%h want 1/%h",
                     icache_rdy, icache_data, mem_word(32'h148));
        else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) begin
                $display("FAIL store_txn: got none want %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL store_txn: got %p want %p", o, e);
                else n_pass++;
            end
        end
        ctrl_stall = 1'b0;
        dcache_en  = 1'b0;
        dcache_wr  = 1'b0;
        step();
        ctrl_stall = 1'b1;
    endtask

    task automatic test_addr_change();
        txn_t e, o;
        icache_addr = 32'h100;
        exp_q.push_back('{1'b0, 32'h100, 32'h0});
        exp_q.push_back('{1'b0, 32'h180, 32'h0});
        step();
        n_total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100)
            $display("FAIL chg_first: got req=%b addr=%h want 1/100",
                     bus.mem_req, bus.mem_addr);
        else n_pass++;
        icache_addr = 32'h180;
        for (int k = 0; k < 10 && bus.mem_req; k++) step();
        n_total++;
        if (icache_rdy !== 1'b0 || bus.mem_req !== 1'b0)
            $display("FAIL chg_stale: got rdy=%b req=%b want 0/0",
                     icache_rdy, bus.mem_req);
        else n_pass++;
        step();
        n_total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h180)
            $display("FAIL chg_refetch: got req=%b addr=%h want 1/180",
                     bus.mem_req, bus.mem_addr);
        else n_pass++;
        for (int k = 0; k < 20 && !icache_rdy; k++) step();
        n_total++;
        if (icache_rdy !== 1'b1 || icache_data !== mem_word(32'h180))
            $display("FAIL chg_data: got rdy=%b data=%h want 1/%h",
                     icache_rdy, icache_data, mem_word(32'h180));
        else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) begin
                $display("FAIL chg_txn: got none want %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL chg_txn: got %p want %p", o, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        txn_t e, o;
        ack_delay   = 0;
        mem_mute    = 1'b1;
        ctrl_stall  = 1'b0;
        dcache_en   = 1'b1;
        dcache_wr   = 1'b0;
        dcache_addr = 32'h400;
        step();
        ctrl_stall = 1'b1;
        n_total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400 ||
            bus.mem_wr !== 1'b0)
            $display("FAIL mid_dreq: got req=%b addr=%h wr=%b want 1/400/0",
                     bus.mem_req, bus.mem_addr, bus.mem_wr);
        else n_pass++;
        repeat (2) step();
        reset = 1'b1;
        step();
        n_total++;
        if (bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h0)
            $display("FAIL mid_abort: got req=%b addr=%h want 0/0",
                     bus.mem_req, bus.mem_addr);
        else n_pass++;
        n_total++;
        if (dcache_rdy !== 1'b0 || icache_rdy !== 1'b0)
            $display("FAIL mid_rdy: got %b/%b want 0/0",
                     dcache_rdy, icache_rdy);
        else n_pass++;
        reset    = 1'b0;
        mem_mute = 1'b0;
        exp_q.push_back('{1'b0, 32'h400, 32'h0});
        exp_q.push_back('{1'b0, 32'h180, 32'h0});
        step();
        n_total++;
        if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400)
            $display("FAIL mid_reissue: got req=%b addr=%h want 1/400",
                     bus.mem_req, bus.mem_addr);
        else n_pass++;
        for (int k = 0; k < 20 && !(icache_rdy && dcache_rdy); k++) step();
        n_total++;
        if (dcache_rdata !== mem_word(32'h400) || icache_rdy !== 1'b1)
            $display("FAIL mid_data: got %h rdy=%b want %h/1",
                     dcache_rdata, icache_rdy, mem_word(32'h400));
        else n_pass++;
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_total++;
            if (obs_q.size() == 0) begin
                $display("FAIL mid_txn: got none want %p", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) $display("FAIL mid_txn: got %p want %p", o, e);
                else n_pass++;
            end
        end
        n_total++;
        if (obs_q.size() !== 0)
            $display("FAIL extra_txn: got %0d leftover want 0", obs_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_collision();
        test_store();
        test_addr_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
